// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: operand/result bus between the sequencer and the shared 4-bit ripple adder
interface adder_seq_ctrl_if;
  logic [3:0] x;
  logic [3:0] y;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  modport master (output x, y, cin, input sum, cout);
  modport slave  (input x, y, cin, output sum, cout);
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: accumulates switch operands through a shared 4-bit adder and converts the sum to BCD digits
module adder_seq_ctrl #(
  parameter int MAX_OPS     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   ENTER_N,
  input  logic                   CLEAR_N,
  input  logic [3:0]             OPERAND,
  adder_seq_ctrl_if.master       add,
  output logic [7:0]             SUM,
  output logic [3:0]             ONES,
  output logic [3:0]             TENS,
  output logic [1:0]             HUNDREDS,
  output logic [7:0]             OP_COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FULL,
  output logic                   OVF
);
  localparam logic [1:0] IDLE = 2'd0, ADD_LO = 2'd1, ADD_HI = 2'd2, CONV = 2'd3;
  logic [1:0]             state;
  logic [2:0]             cnt;
  logic [3:0]             opnd_r, lo_r;
  logic                   c_r;
  logic [9:0]             bcd, adj, nxt;
  logic [SYNC_STAGES-1:0] e_s, c_s;
  logic                   e_q, c_q, e, c;
  assign e = e_q & ~e_s[SYNC_STAGES-1];
  assign c = c_q & ~c_s[SYNC_STAGES-1];
  assign BUSY = state != IDLE;
  assign FULL = OP_COUNT == 8'(MAX_OPS);
  assign add.x = state == ADD_LO ? SUM[3:0] : state == ADD_HI ? SUM[7:4] : 4'd0;
  assign add.y = state == ADD_LO ? opnd_r : 4'd0;
  assign add.cin = state == ADD_HI && c_r;
  // one double-dabble step: correct nibbles >= 5, then shift in the next SUM bit MSB first
  always_comb begin
    adj = {bcd[9:8], bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4], bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0]};
    nxt = {adj[8:0], SUM[~cnt]};
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      e_s <= '1;
      c_s <= '1;
      e_q <= 1'b1;
      c_q <= 1'b1;
    end else begin
      e_s <= {e_s[SYNC_STAGES-2:0], ENTER_N};
      c_s <= {c_s[SYNC_STAGES-2:0], CLEAR_N};
      e_q <= e_s[SYNC_STAGES-1];
      c_q <= c_s[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      opnd_r   <= '0;
      lo_r     <= '0;
      c_r      <= 1'b0;
      bcd      <= '0;
      SUM      <= '0;
      OP_COUNT <= '0;
      OVF      <= 1'b0;
      ONES     <= '0;
      TENS     <= '0;
      HUNDREDS <= '0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (c) begin
        state    <= IDLE;
        cnt      <= '0;
        SUM      <= '0;
        OP_COUNT <= '0;
        OVF      <= 1'b0;
        ONES     <= '0;
        TENS     <= '0;
        HUNDREDS <= '0;
      end else begin
        case (state)
          IDLE: if (e && !FULL) begin
            opnd_r <= OPERAND;
            state  <= ADD_LO;
          end
          ADD_LO: begin
            lo_r  <= add.sum;
            c_r   <= add.cout;
            state <= ADD_HI;
          end
          ADD_HI: begin
            SUM      <= {add.sum, lo_r};
            OP_COUNT <= OP_COUNT + 8'd1;
            OVF      <= OVF | add.cout;
            bcd      <= '0;
            cnt      <= '0;
            state    <= CONV;
          end
          CONV: begin
            bcd <= nxt;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ONES     <= nxt[3:0];
              TENS     <= nxt[7:4];
              HUNDREDS <= nxt[9:8];
              DONE     <= 1'b1;
              state    <= IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized and directed checks of the accumulator/BCD sequencer against an arithmetic model
module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [3:0] opnd;
  logic       enter_n [2];
  logic       clear_n [2];
  logic [7:0] sum_o [2], cnt_o [2];
  logic [3:0] ones_o [2], tens_o [2], x_o [2], y_o [2];
  logic [1:0] hun_o [2];
  logic       busy_o [2], done_o [2], full_o [2], ovf_o [2], cin_o [2];
  int checks = 0, errors = 0;
  int m_sum [2], m_cnt [2];
  int mx [2] = '{15, 20};
  bit m_ovf [2];
  adder_seq_ctrl_if ab0 ();
  adder_seq_ctrl_if ab1 ();
  // behavioural stand-in for the external ripple adders
  assign {ab0.cout, ab0.sum} = {1'b0, ab0.x} + {1'b0, ab0.y} + {4'd0, ab0.cin};
  assign {ab1.cout, ab1.sum} = {1'b0, ab1.x} + {1'b0, ab1.y} + {4'd0, ab1.cin};
  assign x_o[0] = ab0.x;
  assign y_o[0] = ab0.y;
  assign cin_o[0] = ab0.cin;
  assign x_o[1] = ab1.x;
  assign y_o[1] = ab1.y;
  assign cin_o[1] = ab1.cin;
  adder_seq_ctrl #(.MAX_OPS(15), .SYNC_STAGES(2)) dut0 (
    .CLOCK_50(clk), .RESET_N(rst_n), .ENTER_N(enter_n[0]), .CLEAR_N(clear_n[0]), .OPERAND(opnd), .add(ab0),
    .SUM(sum_o[0]), .ONES(ones_o[0]), .TENS(tens_o[0]), .HUNDREDS(hun_o[0]), .OP_COUNT(cnt_o[0]),
    .BUSY(busy_o[0]), .DONE(done_o[0]), .FULL(full_o[0]), .OVF(ovf_o[0]));
  adder_seq_ctrl #(.MAX_OPS(20), .SYNC_STAGES(2)) dut1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .ENTER_N(enter_n[1]), .CLEAR_N(clear_n[1]), .OPERAND(opnd), .add(ab1),
    .SUM(sum_o[1]), .ONES(ones_o[1]), .TENS(tens_o[1]), .HUNDREDS(hun_o[1]), .OP_COUNT(cnt_o[1]),
    .BUSY(busy_o[1]), .DONE(done_o[1]), .FULL(full_o[1]), .OVF(ovf_o[1]));
  task automatic model_reset(input int d);
    m_sum[d] = 0;
    m_cnt[d] = 0;
    m_ovf[d] = 1'b0;
  endtask
  task automatic model_add(input int d, input int op, output bit acc, output bit carry);
    acc = m_cnt[d] < mx[d];
    carry = acc && ((m_sum[d] % 16) + op) > 15;
    if (acc) begin
      m_ovf[d] = m_ovf[d] | (m_sum[d] + op > 255);
      m_sum[d] = (m_sum[d] + op) % 256;
      m_cnt[d]++;
    end
  endtask
  // one ENTER press, then observe the whole transaction window
  task automatic press(input int d, input logic [3:0] op, output int busy_n, output int done_n,
                       output bit lat_ok, output bit cin_seen, output bit stable);
    logic [9:0] dig;
    int last_b, done_at;
    busy_n = 0; done_n = 0; cin_seen = 0; stable = 1; last_b = -10; done_at = -1;
    dig = {hun_o[d], tens_o[d], ones_o[d]};
    @(negedge clk);
    opnd = op;
    enter_n[d] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1) enter_n[d] = 1'b1;
      if (busy_o[d]) begin
        busy_n++;
        last_b = i;
        if (cin_o[d]) cin_seen = 1;
        if ({hun_o[d], tens_o[d], ones_o[d]} !== dig) stable = 0;
      end
      if (done_o[d]) begin
        done_n++;
        done_at = i;
      end
    end
    lat_ok = done_at == last_b + 1;
  endtask
  task automatic drive_clear(input int d, output int done_n);
    done_n = 0;
    @(negedge clk);
    clear_n[d] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) clear_n[d] = 1'b1;
      if (done_o[d]) done_n++;
    end
    model_reset(d);
  endtask
  task automatic test_reset;
    int bad;
    rst_n = 1'b0;
    enter_n = '{1'b1, 1'b1};
    clear_n = '{1'b1, 1'b1};
    opnd = 4'd0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({sum_o[d], ones_o[d], tens_o[d], hun_o[d], cnt_o[d], busy_o[d], done_o[d], full_o[d], ovf_o[d]} !== 34'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got sum=%0d cnt=%0d busy=%b done=%b full=%b ovf=%b exp all 0", d, sum_o[d], cnt_o[d], busy_o[d], done_o[d], full_o[d], ovf_o[d]);
      end
      checks++;
      if ({x_o[d], y_o[d], cin_o[d]} !== 9'd0) begin
        errors++;
        $display("FAIL reset_adder_bus dut%0d got x=%0d y=%0d cin=%b exp 0", d, x_o[d], y_o[d], cin_o[d]);
      end
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o[0] || done_o[0] || busy_o[1] || done_o[1]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_release_quiet got %0d busy/done cycles exp 0", bad);
    end
  endtask
  task automatic test_single;
    int bn, dn;
    bit lat, cs, st, acc, cy;
    press(0, 4'd5, bn, dn, lat, cs, st);
    model_add(0, 5, acc, cy);
    checks++;
    if (bn != 10) begin errors++; $display("FAIL single_busy_cycles got %0d exp 10", bn); end
    checks++;
    if (dn != 1 || !lat) begin errors++; $display("FAIL single_done got pulses=%0d after_busy=%b exp 1/1", dn, lat); end
    checks++;
    if (sum_o[0] !== 8'd5 || cnt_o[0] !== 8'd1) begin errors++; $display("FAIL single_sum got sum=%0d cnt=%0d exp 5/1", sum_o[0], cnt_o[0]); end
    checks++;
    if ({hun_o[0], tens_o[0], ones_o[0]} !== {2'd0, 4'd0, 4'd5}) begin
      errors++;
      $display("FAIL single_digits got %0d/%0d/%0d exp 0/0/5", hun_o[0], tens_o[0], ones_o[0]);
    end
  endtask
  task automatic test_nines;
    int bn, dn, dc;
    bit lat, cs, st, acc, cy;
    drive_clear(0, dc);
    for (int k = 0; k < 3; k++) begin
      press(0, 4'd9, bn, dn, lat, cs, st);
      model_add(0, 9, acc, cy);
      checks++;
      if (cs !== cy) begin errors++; $display("FAIL nines_carry step%0d got cin=%b exp %b", k, cs, cy); end
      checks++;
      if (!st) begin errors++; $display("FAIL nines_digit_stability step%0d got changed exp stable", k); end
    end
    checks++;
    if (sum_o[0] !== 8'd27 || {hun_o[0], tens_o[0], ones_o[0]} !== {2'd0, 4'd2, 4'd7}) begin
      errors++;
      $display("FAIL nines_result got sum=%0d %0d/%0d/%0d exp 27 0/2/7", sum_o[0], hun_o[0], tens_o[0], ones_o[0]);
    end
  endtask
  task automatic test_full;
    int bn, dn, dc, bad;
    bit lat, cs, st, acc, cy;
    drive_clear(0, dc);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      press(0, 4'd15, bn, dn, lat, cs, st);
      model_add(0, 15, acc, cy);
      if (bn != 10 || dn != 1 || !lat || cs !== cy) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_transactions got %0d bad exp 0", bad); end
    checks++;
    if (sum_o[0] !== 8'(m_sum[0]) || {hun_o[0], tens_o[0], ones_o[0]} !== {2'd2, 4'd2, 4'd5}) begin
      errors++;
      $display("FAIL full_result got sum=%0d %0d/%0d/%0d exp %0d 2/2/5", sum_o[0], hun_o[0], tens_o[0], ones_o[0], m_sum[0]);
    end
    checks++;
    if (full_o[0] !== 1'b1 || ovf_o[0] !== 1'b0 || cnt_o[0] !== 8'd15) begin
      errors++;
      $display("FAIL full_flags got full=%b ovf=%b cnt=%0d exp 1/0/15", full_o[0], ovf_o[0], cnt_o[0]);
    end
    press(0, 4'd15, bn, dn, lat, cs, st);
    model_add(0, 15, acc, cy);
    checks++;
    if (bn != 0 || dn != 0 || acc) begin errors++; $display("FAIL full_drop got busy=%0d done=%0d exp 0/0", bn, dn); end
    checks++;
    if (sum_o[0] !== 8'd225 || cnt_o[0] !== 8'd15) begin
      errors++;
      $display("FAIL full_hold got sum=%0d cnt=%0d exp 225/15", sum_o[0], cnt_o[0]);
    end
  endtask
  task automatic test_wrap;
    int bn, dn, dc, bad;
    bit lat, cs, st, acc, cy;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      press(1, 4'd15, bn, dn, lat, cs, st);
      model_add(1, 15, acc, cy);
      if (bn != 10 || dn != 1 || cs !== cy || sum_o[1] !== 8'(m_sum[1]) || ovf_o[1] !== m_ovf[1]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_steps got %0d bad exp 0", bad); end
    checks++;
    if (sum_o[1] !== 8'd44 || ovf_o[1] !== 1'b1 || full_o[1] !== 1'b1 || {hun_o[1], tens_o[1], ones_o[1]} !== {2'd0, 4'd4, 4'd4}) begin
      errors++;
      $display("FAIL wrap_result got sum=%0d ovf=%b full=%b %0d/%0d/%0d exp 44 1 1 0/4/4", sum_o[1], ovf_o[1], full_o[1], hun_o[1], tens_o[1], ones_o[1]);
    end
    drive_clear(1, dc);
    checks++;
    if (sum_o[1] !== 8'd0 || ovf_o[1] !== 1'b0 || full_o[1] !== 1'b0 || cnt_o[1] !== 8'd0 || dc != 0) begin
      errors++;
      $display("FAIL wrap_clear got sum=%0d ovf=%b full=%b cnt=%0d done=%0d exp 0", sum_o[1], ovf_o[1], full_o[1], cnt_o[1], dc);
    end
    checks++;
    if ({hun_o[1], tens_o[1], ones_o[1]} !== 10'd0) begin
      errors++;
      $display("FAIL wrap_clear_digits got %0d/%0d/%0d exp 0/0/0", hun_o[1], tens_o[1], ones_o[1]);
    end
  endtask
  task automatic test_random;
    int bn, dn, dc;
    bit lat, cs, st, acc, cy;
    logic [3:0] op;
    drive_clear(0, dc);
    for (int k = 0; k < 14; k++) begin
      op = 4'($urandom_range(0, 15));
      press(0, op, bn, dn, lat, cs, st);
      model_add(0, int'(op), acc, cy);
      checks++;
      if (sum_o[0] !== 8'(m_sum[0]) || cnt_o[0] !== 8'(m_cnt[0]) || ovf_o[0] !== m_ovf[0] || cs !== cy) begin
        errors++;
        $display("FAIL random_acc op=%0d got sum=%0d cnt=%0d ovf=%b cin=%b exp %0d/%0d/%b/%b", op, sum_o[0], cnt_o[0], ovf_o[0], cs, m_sum[0], m_cnt[0], m_ovf[0], cy);
      end
      checks++;
      if (ones_o[0] !== 4'(m_sum[0] % 10) || tens_o[0] !== 4'((m_sum[0] / 10) % 10) || hun_o[0] !== 2'(m_sum[0] / 100)) begin
        errors++;
        $display("FAIL random_digits got %0d/%0d/%0d exp %0d", hun_o[0], tens_o[0], ones_o[0], m_sum[0]);
      end
      checks++;
      if (bn != 10 || dn != 1 || !lat || !st) begin
        errors++;
        $display("FAIL random_timing got busy=%0d done=%0d after_busy=%b stable=%b exp 10/1/1/1", bn, dn, lat, st);
      end
    end
  endtask
  task automatic test_enter_conv;
    int dn, dc;
    bit acc, cy;
    drive_clear(0, dc);
    dn = 0;
    @(negedge clk);
    opnd = 4'd3;
    enter_n[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1 || i == 7) enter_n[0] = 1'b1;
      if (i == 5) begin
        opnd = 4'd7;
        enter_n[0] = 1'b0;
      end
      if (done_o[0]) dn++;
    end
    model_add(0, 3, acc, cy);
    checks++;
    if (dn != 1 || sum_o[0] !== 8'd3 || cnt_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL enter_in_conv got done=%0d sum=%0d cnt=%0d exp 1/3/1", dn, sum_o[0], cnt_o[0]);
    end
  endtask
  task automatic test_clear_hi;
    int dn;
    dn = 0;
    @(negedge clk);
    opnd = 4'd4;
    enter_n[0] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) enter_n[0] = 1'b1;
      if (i == 1) clear_n[0] = 1'b0;
      if (i == 3) clear_n[0] = 1'b1;
      if (done_o[0]) dn++;
    end
    model_reset(0);
    checks++;
    if (dn != 0 || sum_o[0] !== 8'd0 || cnt_o[0] !== 8'd0 || busy_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_add_hi got done=%0d sum=%0d cnt=%0d busy=%b ovf=%b exp 0", dn, sum_o[0], cnt_o[0], busy_o[0], ovf_o[0]);
    end
  endtask
  task automatic test_reset_conv;
    int bn, dn, dc;
    bit lat, cs, st, acc, cy;
    press(0, 4'd9, bn, dn, lat, cs, st);
    model_add(0, 9, acc, cy);
    @(negedge clk);
    opnd = 4'd6;
    enter_n[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 1) enter_n[0] = 1'b1;
    end
    checks++;
    if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL reset_conv_busy got %b exp 1", busy_o[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_o[0], ones_o[0], tens_o[0], hun_o[0], cnt_o[0], busy_o[0], done_o[0], ovf_o[0]} !== 33'd0) begin
      errors++;
      $display("FAIL reset_conv_async got sum=%0d cnt=%0d busy=%b done=%b ovf=%b exp 0", sum_o[0], cnt_o[0], busy_o[0], done_o[0], ovf_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(0);
    model_reset(1);
    dc = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy_o[0] || done_o[0]) dc++;
    end
    checks++;
    if (dc != 0 || sum_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset_conv_after got activity=%0d sum=%0d exp 0/0", dc, sum_o[0]);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_nines;
    test_full;
    test_wrap;
    test_random;
    test_enter_conv;
    test_clear_hi;
    test_reset_conv;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer for the shared 4-bit ripple adder and BCD display path on the DE2-70.
- Accumulates a series of 4-bit switch operands into an 8-bit running sum, time-multiplexing one external 4-bit adder over two cycles per add.
- Converts the sum to BCD iteratively (shift-add-3, one bit per cycle) and holds ONES/TENS/HUNDREDS stable for the hex_7seg decoders.

Parameters:
- MAX_OPS, 15: number of accepted operands before further ENTER presses are ignored (1..255).
- SYNC_STAGES, 2: synchronizer flops on each KEY input (>=2).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous active-low reset (top level drives it from KEY[0]).
- ENTER_N  in  1  raw active-low push button, already debounced; a press accepts OPERAND.
- CLEAR_N  in  1  raw active-low push button, already debounced; a press clears the accumulator.
- OPERAND  in  4  operand from SW[3:0].
- ADD_X  out  4  adder input x.
- ADD_Y  out  4  adder input y.
- ADD_CIN  out  1  adder carry-in.
- ADD_SUM  in  4  combinational adder sum.
- ADD_COUT  in  1  combinational adder carry-out.
- SUM  out  8  accumulator value.
- ONES  out  4  BCD ones digit.
- TENS  out  4  BCD tens digit.
- HUNDREDS  out  2  BCD hundreds digit.
- OP_COUNT  out  8  operands accepted since clear.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when the digits update.
- FULL  out  1  OP_COUNT == MAX_OPS.
- OVF  out  1  sticky flag: the sum wrapped past 255.

Behaviour:
- Reset (async, RESET_N low): state IDLE. SUM, ONES, TENS, HUNDREDS, OP_COUNT and OVF are 0; DONE and BUSY are 0; ADD_X, ADD_Y and ADD_CIN are 0. Synchronizer flops are preset to 1 (button released).
- Inputs: each KEY input passes through SYNC_STAGES flops. A press is the registered 1->0 transition of the synchronized signal and is a one-cycle event (E = enter, C = clear).
- States: IDLE, ADD_LO, ADD_HI, CONV, plus an internal bit counter 0..7.
- IDLE, on E with FULL=0: latch OPERAND into opnd_r and go to ADD_LO. E with FULL=1 is dropped.
- ADD_LO: drive ADD_X=SUM[3:0], ADD_Y=opnd_r, ADD_CIN=0. Register ADD_SUM into lo_r and ADD_COUT into c_r. Go to ADD_HI.
- ADD_HI: drive ADD_X=SUM[7:4], ADD_Y=0, ADD_CIN=c_r. At the clock edge, SUM <= {ADD_SUM, lo_r} and OP_COUNT increments. OVF is set if ADD_COUT=1. Go to CONV.
- Outside ADD_LO and ADD_HI, ADD_X, ADD_Y and ADD_CIN are 0.
- CONV: 8 cycles of double-dabble on a 10-bit BCD shadow register. On each cycle, add 3 to any nibble >=5, then shift in SUM bits MSB first.
- Conversion end: after the 8th cycle, ONES, TENS and HUNDREDS load from the shadow register, DONE pulses for one cycle, and the state returns to IDLE.
- Latency: the E edge-detect cycle is T. The digits are valid and DONE=1 at T+11 (1 + 2 add + 8 conv). The digit outputs do not change mid-conversion.
- E while BUSY: dropped, not queued.
- C in any state: has priority over E in the same cycle. It aborts any operation and returns to IDLE next cycle. SUM, OP_COUNT, OVF and all digits go to 0; DONE is not pulsed.
- Wrap-around: the sum is modulo 256. OVF stays set until C or reset.
- FULL is combinational from OP_COUNT.
- RESET_N asserted mid-operation: immediate return to reset values; no partial SUM update is retained.

Test Plan:
- Reset with ENTER_N and CLEAR_N held high -> all outputs 0, BUSY=0; after release, no spurious DONE.
- OPERAND=5 and one ENTER press -> BUSY high for 10 cycles. DONE at T+11. SUM=5, digits 0/0/5, OP_COUNT=1.
- Operands 9, 9, 9 entered sequentially -> SUM=27, TENS=2, ONES=7, HUNDREDS=0. A 9+9 step must check carry across nibbles: low-nibble carry propagates via ADD_CIN=1 in ADD_HI.
- 15 presses with OPERAND=15 (MAX_OPS=15) -> SUM=225, digits 2/2/5, FULL=1, OVF=0. A 16th press leaves SUM and OP_COUNT unchanged and BUSY stays low.
- MAX_OPS=20, 20 presses of 15 -> SUM=44 (300 mod 256), OVF=1. A following CLEAR -> SUM=0, OVF=0, FULL=0.
- ENTER pressed during CONV -> ignored, only one increment. CLEAR asserted in ADD_HI -> SUM=0 next cycle, no DONE. RESET_N pulsed low in CONV -> all outputs 0 asynchronously.
